// File: rtl/sdram_burst_master.sv
// SDRAM burst master: runs one read/write burst (with auto-precharge), refresh
// or load-mode sequence per request and inserts periodic refreshes.
// All SDRAM-side outputs are registered; the comb block computes the next
// cycle's values from the current cycle index within the sequence.
module sdram_burst_master #(
    parameter int ADDR_WIDTH       = 11,
    parameter int DATA_WIDTH       = 16,
    parameter int BANKSEL_WIDTH    = 2,
    parameter int COL_WIDTH        = 8,
    parameter int BURST_LEN        = 4,
    parameter int CAS_LAT          = 2,
    parameter int T_RCD            = 2,
    parameter int T_RP             = 2,
    parameter int T_WR             = 2,
    parameter int T_RFC            = 7,
    parameter int T_MRD            = 2,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [BANKSEL_WIDTH-1:0] req_bank,
    input  logic [ADDR_WIDTH-1:0]    req_row,
    input  logic [COL_WIDTH-1:0]     req_col,
    input  logic [ADDR_WIDTH-1:0]    req_mode,
    output logic                     wdata_ready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH/8-1:0]  wmask,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     cke,
    output logic                     cs_n,
    output logic                     ras_n,
    output logic                     cas_n,
    output logic                     we_n,
    output logic [BANKSEL_WIDTH-1:0] bs,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [DATA_WIDTH/8-1:0]  dqm,
    output logic [DATA_WIDTH-1:0]    dq_o,
    output logic                     dq_oe,
    input  logic [DATA_WIDTH-1:0]    dq_i
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_REFRESH, S_LOADMODE} state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_WRIT = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam logic [3:0] CMD_DESL = 4'b1111;

    localparam logic [ADDR_WIDTH-1:0] A10 = ADDR_WIDTH'(1024);

    // Cycle indices relative to c0 (the cycle showing the first command)
    localparam logic [31:0] RCD          = 32'(T_RCD);
    localparam logic [31:0] RD_FIRST     = 32'(T_RCD + CAS_LAT);
    localparam logic [31:0] RD_LAST      = 32'(T_RCD + CAS_LAT + BURST_LEN - 1);
    localparam logic [31:0] RD_DONE      = 32'(T_RCD + CAS_LAT + BURST_LEN - 1 + T_RP + 1);
    localparam logic [31:0] WR_RDY_FIRST = 32'(T_RCD - 1);
    localparam logic [31:0] WR_RDY_LAST  = 32'(T_RCD + BURST_LEN - 2);
    localparam logic [31:0] WR_DONE      = 32'(T_RCD + BURST_LEN - 1 + T_WR + T_RP + 1);
    localparam logic [31:0] RP           = 32'(T_RP);
    localparam logic [31:0] REF_DONE     = 32'(T_RP + T_RFC);
    localparam logic [31:0] LMR_DONE     = 32'(T_MRD);
    localparam logic [31:0] TIMER_RELOAD = 32'(REFRESH_INTERVAL - 1);

    state_t                     state_q, state_d;
    logic [31:0]                cnt_q, cnt_d;
    logic [31:0]                timer_q, timer_d;
    logic                       pending_q, pending_d;
    logic [BANKSEL_WIDTH-1:0]   bank_q, bank_d;
    logic [COL_WIDTH-1:0]       col_q, col_d;
    logic [3:0]                 cmd_q, cmd_d;
    logic                       cke_q;
    logic [BANKSEL_WIDTH-1:0]   bs_q, bs_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH/8-1:0]    dqm_q, dqm_d;
    logic [DATA_WIDTH-1:0]      dq_o_q, dq_o_d;
    logic                       dq_oe_q, dq_oe_d;
    logic                       req_ready_q, req_ready_d;
    logic                       wdata_ready_q, wdata_ready_d;
    logic                       rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
    logic [31:0]                n;
    logic                       go_idle;
    logic                       ref_start;

    // Next-state, next-output and refresh-timer logic
    always_comb begin
        state_d       = state_q;
        n             = cnt_q + 32'd1;
        cnt_d         = n;
        bank_d        = bank_q;
        col_d         = col_q;
        cmd_d         = CMD_NOP;
        bs_d          = '0;
        addr_d        = '0;
        dqm_d         = '0;
        dq_o_d        = '0;
        dq_oe_d       = 1'b0;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        wdata_ready_d = 1'b0;
        go_idle       = 1'b0;
        ref_start     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    ref_start = 1'b1;
                    state_d   = S_REFRESH;
                    cnt_d     = '0;
                    cmd_d     = CMD_PRE;
                    addr_d    = A10;
                end else if (req_valid && req_ready_q) begin
                    cnt_d = '0;
                    case (req_op)
                        2'b00, 2'b01: begin
                            state_d       = (req_op == 2'b00) ? S_READ : S_WRITE;
                            cmd_d         = CMD_ACT;
                            bs_d          = req_bank;
                            addr_d        = req_row;
                            bank_d        = req_bank;
                            col_d         = req_col;
                            // with T_RCD=1 the first data slot already opens at c0
                            wdata_ready_d = (req_op == 2'b01) && (WR_RDY_FIRST == '0);
                        end
                        2'b10: begin
                            ref_start = 1'b1;
                            state_d   = S_REFRESH;
                            cmd_d     = CMD_PRE;
                            addr_d    = A10;
                        end
                        default: begin
                            state_d = S_LOADMODE;
                            cmd_d   = CMD_LMR;
                            addr_d  = req_mode;
                        end
                    endcase
                end else begin
                    go_idle = 1'b1;
                end
            end
            S_READ: begin
                if (n == RCD) begin
                    cmd_d  = CMD_READ;
                    bs_d   = bank_q;
                    addr_d = A10 | ADDR_WIDTH'(col_q);
                end
                if (cnt_q >= RD_FIRST && cnt_q <= RD_LAST) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = dq_i;
                end
                if (n == RD_DONE) begin
                    state_d = S_IDLE;
                    go_idle = 1'b1;
                end
            end
            S_WRITE: begin
                if (n == RCD) begin
                    cmd_d  = CMD_WRIT;
                    bs_d   = bank_q;
                    addr_d = A10 | ADDR_WIDTH'(col_q);
                end
                wdata_ready_d = (n >= WR_RDY_FIRST) && (n <= WR_RDY_LAST);
                if (wdata_ready_q) begin
                    dq_oe_d = 1'b1;
                    dq_o_d  = wdata;
                    dqm_d   = wmask;
                end
                if (n == WR_DONE) begin
                    state_d = S_IDLE;
                    go_idle = 1'b1;
                end
            end
            S_REFRESH: begin
                if (n == RP) cmd_d = CMD_AREF;
                if (n == REF_DONE) begin
                    state_d = S_IDLE;
                    go_idle = 1'b1;
                end
            end
            S_LOADMODE: begin
                if (n == LMR_DONE) begin
                    state_d = S_IDLE;
                    go_idle = 1'b1;
                end
            end
        endcase

        // Starting a refresh wins over a coincident expiry; expiry while
        // already pending just reloads.
        if (ref_start) begin
            timer_d   = TIMER_RELOAD;
            pending_d = 1'b0;
        end else if (timer_q == '0) begin
            timer_d   = TIMER_RELOAD;
            pending_d = 1'b1;
        end else begin
            timer_d   = timer_q - 32'd1;
            pending_d = pending_q;
        end

        req_ready_d = go_idle && !pending_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            timer_q       <= TIMER_RELOAD;
            pending_q     <= 1'b0;
            bank_q        <= '0;
            col_q         <= '0;
            cmd_q         <= CMD_DESL;
            cke_q         <= 1'b1;
            bs_q          <= '0;
            addr_q        <= '0;
            dqm_q         <= '0;
            dq_o_q        <= '0;
            dq_oe_q       <= 1'b0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            bank_q        <= bank_d;
            col_q         <= col_d;
            cmd_q         <= cmd_d;
            cke_q         <= 1'b1;
            bs_q          <= bs_d;
            addr_q        <= addr_d;
            dqm_q         <= dqm_d;
            dq_o_q        <= dq_o_d;
            dq_oe_q       <= dq_oe_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign cke         = cke_q;
    assign bs          = bs_q;
    assign addr        = addr_q;
    assign dqm         = dqm_q;
    assign dq_o        = dq_o_q;
    assign dq_oe       = dq_oe_q;
    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_sdram_burst_master.sv
// Bench for sdram_burst_master: directed and randomized transactions checked
// against a cycle schedule computed from the command timing rules, plus a
// back-to-back read run with a short refresh interval.
module tb_sdram_burst_master;

    localparam int AW = 11, DW = 16, BW = 2, CW = 8, MW = 2;
    localparam int T_RCD = 2, CAS_LAT = 2, BURST_LEN = 4, T_RP = 2, T_WR = 2, T_RFC = 7, T_MRD = 2;
    localparam int RI2 = 64;
    localparam int NCAP = 14;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;
    localparam logic [AW-1:0] A10 = 11'h400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1 (default parameters)
    logic rst, req_valid, req_ready, wdata_ready, rd_valid, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
    logic [1:0] req_op;
    logic [BW-1:0] req_bank, bs;
    logic [AW-1:0] req_row, req_mode, addr;
    logic [CW-1:0] req_col;
    logic [DW-1:0] wdata, rd_data, dq_o, dq_i;
    logic [MW-1:0] wmask, dqm;

    // DUT 2 (short refresh interval)
    logic rst2, req_valid2, req_ready2, wdata_ready2, rd_valid2, cke2, cs_n2, ras_n2, cas_n2, we_n2, dq_oe2;
    logic [1:0] req_op2;
    logic [BW-1:0] req_bank2, bs2;
    logic [AW-1:0] req_row2, req_mode2, addr2;
    logic [CW-1:0] req_col2;
    logic [DW-1:0] wdata2, rd_data2, dq_o2, dq_i2;
    logic [MW-1:0] wmask2, dqm2;

    sdram_burst_master dut (
        .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_mode(req_mode),
        .wdata_ready(wdata_ready), .wdata(wdata), .wmask(wmask), .rd_valid(rd_valid), .rd_data(rd_data),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bs(bs), .addr(addr),
        .dqm(dqm), .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i)
    );

    sdram_burst_master #(.REFRESH_INTERVAL(RI2)) dut2 (
        .clock(clk), .reset(rst2), .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op2),
        .req_bank(req_bank2), .req_row(req_row2), .req_col(req_col2), .req_mode(req_mode2),
        .wdata_ready(wdata_ready2), .wdata(wdata2), .wmask(wmask2), .rd_valid(rd_valid2), .rd_data(rd_data2),
        .cke(cke2), .cs_n(cs_n2), .ras_n(ras_n2), .cas_n(cas_n2), .we_n(we_n2), .bs(bs2), .addr(addr2),
        .dqm(dqm2), .dq_o(dq_o2), .dq_oe(dq_oe2), .dq_i(dq_i2)
    );

    int tests = 0;
    int fails = 0;

    // Per-cycle capture of one transaction, index 0 = c0
    logic [3:0]    cap_cmd [NCAP];
    logic [BW-1:0] cap_bs [NCAP];
    logic [AW-1:0] cap_addr [NCAP];
    logic          cap_rv [NCAP], cap_ready [NCAP], cap_oe [NCAP], cap_wrdy [NCAP];
    logic [DW-1:0] cap_rd [NCAP], cap_dqo [NCAP];
    logic [MW-1:0] cap_dqm [NCAP];
    logic [DW-1:0] dqin [NCAP];
    logic [DW-1:0] wd [BURST_LEN];
    logic [MW-1:0] wm [BURST_LEN];

    // Issue one request, then record NCAP cycles while playing dq_i and write data
    task automatic run_txn(input logic [1:0] op, input logic [BW-1:0] b, input logic [AW-1:0] r,
                           input logic [CW-1:0] c, input logic [AW-1:0] m, input int rst_at);
        int w = 0;
        int beat = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_wait req_ready=%b required=1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_bank = b; req_row = r; req_col = c; req_mode = m;
        @(posedge clk);
        for (int k = 0; k < NCAP; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            cap_cmd[k] = {cs_n, ras_n, cas_n, we_n};
            cap_bs[k] = bs; cap_addr[k] = addr; cap_rv[k] = rd_valid; cap_rd[k] = rd_data;
            cap_ready[k] = req_ready; cap_oe[k] = dq_oe; cap_wrdy[k] = wdata_ready;
            cap_dqo[k] = dq_o; cap_dqm[k] = dqm;
            dq_i = dqin[k];
            if (wdata_ready && beat < BURST_LEN) begin
                wdata = wd[beat];
                wmask = wm[beat];
                beat++;
            end
            if (k == rst_at) rst = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({cs_n, ras_n, cas_n, we_n, cke, dq_oe, req_ready, wdata_ready, rd_valid} !== 9'b11111_0000) begin
            fails++;
            $display("FAIL reset_ctrl got=%b required=111110000",
                     {cs_n, ras_n, cas_n, we_n, cke, dq_oe, req_ready, wdata_ready, rd_valid});
        end
        tests++;
        if (addr !== '0 || bs !== '0 || dqm !== '0 || dq_o !== '0 || rd_data !== '0) begin
            fails++;
            $display("FAIL reset_bus addr=%h bs=%h dqm=%h dq_o=%h rd_data=%h required all 0",
                     addr, bs, dqm, dq_o, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || {cs_n, ras_n, cas_n, we_n} !== C_NOP) begin
            fails++;
            $display("FAIL reset_release req_ready=%b cmd=%b required 1/%b", req_ready, {cs_n, ras_n, cas_n, we_n}, C_NOP);
        end
    endtask

    task automatic test_read(input logic [BW-1:0] b, input logic [AW-1:0] r, input logic [CW-1:0] c);
        int done = T_RCD + CAS_LAT + BURST_LEN - 1 + T_RP + 1;
        logic [3:0] ecmd;
        logic [BW-1:0] ebs;
        logic [AW-1:0] eaddr;
        logic erv, erdy;
        run_txn(2'b00, b, r, c, '0, -1);
        for (int k = 0; k <= done; k++) begin
            ecmd = C_NOP; ebs = '0; eaddr = '0;
            if (k == 0) begin
                ecmd = C_ACT; ebs = b; eaddr = r;
            end else if (k == T_RCD) begin
                ecmd = C_RD; ebs = b; eaddr = A10 | AW'(c);
            end
            erv = (k > T_RCD + CAS_LAT) && (k <= T_RCD + CAS_LAT + BURST_LEN);
            erdy = (k == done);
            tests++;
            if ({cap_cmd[k], cap_bs[k], cap_addr[k], cap_rv[k], cap_ready[k], cap_oe[k], cap_wrdy[k]}
                !== {ecmd, ebs, eaddr, erv, erdy, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL read_c%0d cmd/bs/addr/rv/rdy/oe/wrdy=%b/%h/%h/%b/%b/%b/%b required=%b/%h/%h/%b/%b/0/0",
                         k, cap_cmd[k], cap_bs[k], cap_addr[k], cap_rv[k], cap_ready[k], cap_oe[k], cap_wrdy[k],
                         ecmd, ebs, eaddr, erv, erdy);
            end
            if (erv) begin
                tests++;
                if (cap_rd[k] !== dqin[k-1]) begin
                    fails++;
                    $display("FAIL read_data_c%0d rd_data=%h required=%h", k, cap_rd[k], dqin[k-1]);
                end
            end
        end
    endtask

    task automatic test_write(input logic [BW-1:0] b, input logic [AW-1:0] r, input logic [CW-1:0] c);
        int done = T_RCD + BURST_LEN - 1 + T_WR + T_RP + 1;
        logic [3:0] ecmd;
        logic [BW-1:0] ebs;
        logic [AW-1:0] eaddr;
        logic [MW-1:0] edqm;
        logic ewr, eoe, erdy;
        run_txn(2'b01, b, r, c, '0, -1);
        for (int k = 0; k <= done; k++) begin
            ecmd = C_NOP; ebs = '0; eaddr = '0; edqm = '0;
            if (k == 0) begin
                ecmd = C_ACT; ebs = b; eaddr = r;
            end else if (k == T_RCD) begin
                ecmd = C_WR; ebs = b; eaddr = A10 | AW'(c);
            end
            ewr = (k >= T_RCD - 1) && (k <= T_RCD + BURST_LEN - 2);
            eoe = (k >= T_RCD) && (k <= T_RCD + BURST_LEN - 1);
            if (eoe) edqm = wm[k - T_RCD];
            erdy = (k == done);
            tests++;
            if ({cap_cmd[k], cap_bs[k], cap_addr[k], cap_wrdy[k], cap_oe[k], cap_dqm[k], cap_ready[k], cap_rv[k]}
                !== {ecmd, ebs, eaddr, ewr, eoe, edqm, erdy, 1'b0}) begin
                fails++;
                $display("FAIL write_c%0d cmd/bs/addr/wrdy/oe/dqm/rdy/rv=%b/%h/%h/%b/%b/%h/%b/%b required=%b/%h/%h/%b/%b/%h/%b/0",
                         k, cap_cmd[k], cap_bs[k], cap_addr[k], cap_wrdy[k], cap_oe[k], cap_dqm[k], cap_ready[k],
                         cap_rv[k], ecmd, ebs, eaddr, ewr, eoe, edqm, erdy);
            end
            if (eoe) begin
                tests++;
                if (cap_dqo[k] !== wd[k - T_RCD]) begin
                    fails++;
                    $display("FAIL write_data_c%0d dq_o=%h required=%h", k, cap_dqo[k], wd[k - T_RCD]);
                end
            end
        end
    endtask

    task automatic test_refresh;
        int done = T_RP + T_RFC;
        logic [3:0] ecmd;
        logic [AW-1:0] eaddr;
        run_txn(2'b10, BW'($urandom), AW'($urandom), CW'($urandom), '0, -1);
        for (int k = 0; k <= done; k++) begin
            ecmd = (k == 0) ? C_PRE : (k == T_RP) ? C_REF : C_NOP;
            eaddr = (k == 0) ? A10 : '0;
            tests++;
            if ({cap_cmd[k], cap_bs[k], cap_ready[k], cap_oe[k], cap_wrdy[k], cap_rv[k]}
                !== {ecmd, 2'b00, (k == done), 3'b000}) begin
                fails++;
                $display("FAIL refresh_c%0d cmd/bs/rdy/oe/wrdy/rv=%b/%h/%b/%b/%b/%b required=%b/0/%b/0/0/0",
                         k, cap_cmd[k], cap_bs[k], cap_ready[k], cap_oe[k], cap_wrdy[k], cap_rv[k], ecmd, (k == done));
            end
            if (k != T_RP) begin
                tests++;
                if (cap_addr[k] !== eaddr) begin
                    fails++;
                    $display("FAIL refresh_addr_c%0d addr=%h required=%h", k, cap_addr[k], eaddr);
                end
            end
        end
    endtask

    task automatic test_loadmode(input logic [AW-1:0] m);
        logic [3:0] ecmd;
        run_txn(2'b11, BW'($urandom), AW'($urandom), CW'($urandom), m, -1);
        for (int k = 0; k <= T_MRD; k++) begin
            ecmd = (k == 0) ? C_LMR : C_NOP;
            tests++;
            if ({cap_cmd[k], cap_bs[k], cap_addr[k], cap_ready[k], cap_oe[k]}
                !== {ecmd, 2'b00, (k == 0) ? m : 11'h000, (k == T_MRD), 1'b0}) begin
                fails++;
                $display("FAIL loadmode_c%0d cmd/bs/addr/rdy/oe=%b/%h/%h/%b/%b required=%b/0/%h/%b/0",
                         k, cap_cmd[k], cap_bs[k], cap_addr[k], cap_ready[k], cap_oe[k], ecmd,
                         (k == 0) ? m : 11'h000, (k == T_MRD));
            end
        end
    endtask

    task automatic test_reset_midwrite;
        for (int i = 0; i < BURST_LEN; i++) begin
            wd[i] = DW'($urandom);
            wm[i] = MW'($urandom);
        end
        run_txn(2'b01, 2'd3, 11'h0AA, 8'h11, '0, 3);
        for (int k = 1; k <= 3; k++) begin
            tests++;
            if (cap_wrdy[k] !== 1'b1) begin
                fails++;
                $display("FAIL midwrite_wrdy_c%0d wdata_ready=%b required=1", k, cap_wrdy[k]);
            end
        end
        for (int k = 4; k < NCAP; k++) begin
            tests++;
            if ({cap_cmd[k], cap_oe[k], cap_ready[k], cap_wrdy[k]} !== 7'b1111_000) begin
                fails++;
                $display("FAIL midwrite_reset_c%0d cmd/oe/rdy/wrdy=%b/%b/%b/%b required=1111/0/0/0",
                         k, cap_cmd[k], cap_oe[k], cap_ready[k], cap_wrdy[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || cs_n !== 1'b0) begin
            fails++;
            $display("FAIL midwrite_release req_ready=%b cs_n=%b required=1/0", req_ready, cs_n);
        end
        for (int k = 0; k < NCAP; k++) dqin[k] = DW'($urandom);
        test_read(2'd1, 11'h2C3, 8'h5A);
    endtask

    task automatic test_back_to_back;
        logic [3:0] c;
        logic [DW-1:0] last_dq = '0;
        int beats = 0;
        int nref = 0;
        int last_pre = -1;
        bit seen = 0;
        bit open = 0;
        rst2 = 1'b1;
        req_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        req_valid2 = 1'b1;
        req_op2 = 2'b00;
        for (int cyc = 0; cyc < 450; cyc++) begin
            @(negedge clk);
            c = {cs_n2, ras_n2, cas_n2, we_n2};
            if (rd_valid2) begin
                tests++;
                if (rd_data2 !== last_dq) begin
                    fails++;
                    $display("FAIL b2b_data cyc=%0d rd_data=%h required=%h", cyc, rd_data2, last_dq);
                end
                beats++;
                if (beats == BURST_LEN) open = 0;
            end
            if (c == C_ACT) begin
                if (seen) begin
                    tests++;
                    if (beats != BURST_LEN) begin
                        fails++;
                        $display("FAIL b2b_beats cyc=%0d beats=%0d required=%0d", cyc, beats, BURST_LEN);
                    end
                end
                seen = 1; open = 1; beats = 0;
            end
            if (c == C_PRE) begin
                tests++;
                if (open) begin
                    fails++;
                    $display("FAIL b2b_mid_burst cyc=%0d refresh inside open read, required none", cyc);
                end
                if (last_pre >= 0) begin
                    tests++;
                    if (cyc - last_pre < RI2 + 1 || cyc - last_pre > RI2 + 11) begin
                        fails++;
                        $display("FAIL b2b_interval gap=%0d required=%0d..%0d", cyc - last_pre, RI2 + 1, RI2 + 11);
                    end
                end
                last_pre = cyc;
                nref++;
            end
            last_dq = DW'($urandom);
            dq_i2 = last_dq;
            req_bank2 = BW'($urandom);
            req_row2 = AW'($urandom);
            req_col2 = CW'($urandom);
        end
        req_valid2 = 1'b0;
        tests++;
        if (nref < 5 || nref > 7) begin
            fails++;
            $display("FAIL b2b_refresh_count count=%0d required=5..7", nref);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_bank = '0; req_row = '0; req_col = '0;
        req_mode = '0; wdata = '0; wmask = '0; dq_i = '0;
        rst2 = 1'b1; req_valid2 = 1'b0; req_op2 = '0; req_bank2 = '0; req_row2 = '0; req_col2 = '0;
        req_mode2 = '0; wdata2 = '0; wmask2 = '0; dq_i2 = '0;

        test_reset();

        for (int k = 0; k < NCAP; k++) dqin[k] = DW'($urandom);
        for (int k = 4; k < 8; k++) dqin[k] = 16'h00A0 + DW'(k - 4);
        test_read(2'd2, 11'h155, 8'h23);

        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        wm[0] = 2'd0; wm[1] = 2'd0; wm[2] = 2'd3; wm[3] = 2'd0;
        test_write(2'd1, 11'h7FF, 8'hFF);

        test_refresh();
        test_loadmode(11'h022);
        test_reset_midwrite();

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < NCAP; k++) dqin[k] = DW'($urandom);
            for (int k = 0; k < BURST_LEN; k++) begin
                wd[k] = DW'($urandom);
                wm[k] = MW'($urandom);
            end
            case ($urandom_range(0, 5))
                0, 1: test_read(BW'($urandom), AW'($urandom), CW'($urandom));
                2, 3: test_write(BW'($urandom), AW'($urandom), CW'($urandom));
                4: test_loadmode(AW'($urandom));
                default: test_refresh();
            endcase
        end

        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_burst_master.md
SDRAM_BURST_MASTER -- requirements
Module: sdram_burst_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11: SDRAM address bus width, also the row width; must be >= 11.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16: dq width; dqm width is DATA_WIDTH/8.
REQ-003 The block SHALL have parameter BANKSEL_WIDTH, default 2: bank select width.
REQ-004 The block SHALL have parameter COL_WIDTH, default 8: column width; must be <= 10.
REQ-005 The block SHALL have parameters BURST_LEN=4, CAS_LAT=2, T_RCD=2, T_RP=2, T_WR=2, T_RFC=7, T_MRD=2 (cycles, each >= 1) and REFRESH_INTERVAL=780 (cycles, >= 16).
REQ-006 The block SHALL have the following ports, in this order:
- clock  in  1  clock.
- reset  in  1  reset; reset, synchronous, active-high; clock clock.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on edge where valid&ready.
- req_op  in  2  00 read, 01 write, 10 refresh, 11 load mode.
- req_bank  in  BANKSEL_WIDTH.
- req_row  in  ADDR_WIDTH.
- req_col  in  COL_WIDTH.
- req_mode  in  ADDR_WIDTH  mode register value.
- wdata_ready  out  1  wdata/wmask sampled at end of this cycle.
- wdata  in  DATA_WIDTH.
- wmask  in  DATA_WIDTH/8.
- rd_valid  out  1.
- rd_data  out  DATA_WIDTH.
- cke, cs_n, ras_n, cas_n, we_n  out  1 each  SDRAM controls.
- bs  out  BANKSEL_WIDTH.
- addr  out  ADDR_WIDTH.
- dqm  out  DATA_WIDTH/8.
- dq_o  out  DATA_WIDTH.
- dq_oe  out  1.
- dq_i  in  DATA_WIDTH.

Function
REQ-007 All SDRAM-side outputs SHALL be registered; c0 = cycle immediately after the accepting edge (or the internal refresh start edge).
REQ-008 IDLE SHALL drive NOP (cs_n=0, ras_n=cas_n=we_n=1, cke=1, addr=0, bs=0, dqm=0, dq_oe=0); every wait cycle inside a sequence SHALL also be NOP.
REQ-009 req_ready SHALL be 1 only in IDLE with no refresh pending; req_* ignored otherwise.
REQ-010 Read sequence SHALL run as follows:
- ACTIVE at c0 (bs=req_bank, addr=req_row).
- READ at c0+T_RCD (ras_n=1, cas_n=0, we_n=1, addr={A10=1 auto-precharge, col zero-extended}).
- dq_i sampled at end of cycles c0+T_RCD+CAS_LAT .. +BURST_LEN-1; rd_valid/rd_data one cycle later per beat.
- req_ready returns at L+T_RP+1, where L is the last sampled cycle.
REQ-011 Write sequence SHALL run as follows:
- ACTIVE at c0; WRITE at c0+T_RCD (we_n=0, A10=1).
- wdata_ready high in cycles c0+T_RCD-1 .. c0+T_RCD+BURST_LEN-2.
- Each sampled wdata/wmask is driven on dq_o/dqm with dq_oe=1 in the next cycle (beats c0+T_RCD .. W=c0+T_RCD+BURST_LEN-1).
- req_ready returns at W+T_WR+T_RP+1.
REQ-012 Refresh sequence SHALL run as follows:
- PRECHARGE ALL at c0 (ras_n=0, cas_n=1, we_n=0, addr=A10 only).
- AUTO REFRESH at c0+T_RP (ras_n=cas_n=0, we_n=1).
- req_ready returns at c0+T_RP+T_RFC.
REQ-013 Load mode SHALL issue LOAD MODE at c0 (all four low, bs=0, addr=req_mode); req_ready returns at c0+T_MRD.
REQ-014 The refresh timer SHALL work as follows:
- Counts down from REFRESH_INTERVAL-1 every cycle.
- At 0, sets refresh_pending and reloads.
- Expiry while already pending is not counted (no accumulation).
- An internal refresh (REQ-012 sequence) starts on the first edge in IDLE with pending set.
- Starting any refresh (internal or req_op=10) clears pending and reloads the timer.
REQ-015 If the timer expires on the same edge a request is accepted, the request SHALL proceed and the refresh SHALL follow at the next IDLE.
REQ-016 rd_valid and wdata_ready SHALL be single-cycle per beat, exactly BURST_LEN pulses per read/write.

Reset
REQ-017 While reset is high at an edge, outputs SHALL go to the following values and the current sequence is abandoned:
- cs_n=1, ras_n=cas_n=we_n=1, cke=1.
- addr=0, bs=0, dqm=0, dq_o=0, dq_oe=0.
- req_ready=0, wdata_ready=0, rd_valid=0, rd_data=0.
- FSM in IDLE, refresh pending cleared, timer reloaded.
REQ-018 req_ready SHALL be 1 in the first cycle after reset deasserts; NOP (cs_n=0) is driven from then on.

Verification
REQ-019 The bench SHALL cover the following scenarios, with default parameters:
- Read bank 2, row 0x155, col 0x23; dq_i=0xA0..0xA3 in c0+4..c0+7 -> ACTIVE c0 (bs=2, addr=0x155); READ c0+2 (addr=0x423); rd_data 0xA0..0xA3 with rd_valid c0+5..c0+8; req_ready c0+10.
- Write bank 1, row 0x7FF, col 0xFF, wdata 0x1111..0x4444, wmask 0,0,3,0 -> wdata_ready c0+1..c0+4; WRITE c0+2 (addr=0x4FF); dq_oe=1 c0+2..c0+5 with matching dq_o/dqm; req_ready c0+10.
- Refresh request -> PRECHARGE ALL c0 (addr=0x400); AUTO REFRESH c0+2; req_ready c0+9.
- Load mode 0x022 -> LOAD MODE c0 (addr=0x022); req_ready c0+2.
- REFRESH_INTERVAL=64, req_valid held high with back-to-back reads -> internal refresh inserted between reads, one per 64 cycles, never mid-burst.
- Reset asserted in c0+3 of a write -> next cycle cs_n=1, dq_oe=0, req_ready=0, no further wdata_ready; after release, req_ready=1 and the next read is exact per REQ-010.
